xdpram_port_master: RTL and testbench

//   Request/response initiator for one port of the team's single-clock true dual-port BRAM.
//   - Accepts valid/ready read and write requests from a client.
//   - Drives the RAM port pins: addr, din, we, en, regce and rst.
//   - Tracks the RAM read latency of 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE) cycles.
//   - Returns read data in request order through a credit-protected response FIFO with backpressure.
//   One instance sits between each client engine and each RAM port.

---
 rtl/xdpram_port_master.sv | 150 +++++++++++++++
 tb/tb_xdpram_port_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdpram_port_master.sv
// rtl/xdpram_port_master.sv - valid/ready request initiator for one port of a single-clock true dual-port BRAM
module xdpram_port_master #(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 64,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4,
    parameter int WR_RSP     = 0,
    // Equivalent to clogb2(RAM_DEPTH-1): number of bits to address RAM_DEPTH entries
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AW-1:0]        req_addr,
    input  logic [RAM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RAM_WIDTH-1:0] rsp_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [RAM_WIDTH-1:0] ram_din,
    output logic                 ram_regce,
    output logic                 ram_rst,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic                 busy
);

    localparam int            CW           = $clog2(RSP_DEPTH + 1);
    localparam int            PW           = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] CREDITS_FULL = CW'(RSP_DEPTH);
    localparam logic          TRACK_WRITES = (WR_RSP != 0);

    logic [CW-1:0]        credits;
    logic [CW-1:0]        credits_next;
    logic [CW-1:0]        count;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [RAM_WIDTH-1:0] fifo [RSP_DEPTH];
    logic                 busy_q;
    logic                 accept;
    logic                 tracked;
    logic                 push;
    logic                 pop;
    logic                 tag0;
    logic                 push_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready comes from registered credits only, so it never loops through the client's valid
    assign req_ready = (credits != '0) & ~rstb;
    assign accept    = req_valid & req_ready;
    assign tracked   = accept & (~req_we | TRACK_WRITES);

    assign ram_en    = accept;
    assign ram_we    = accept & req_we;
    assign ram_addr  = req_addr;
    assign ram_din   = req_wdata;
    assign ram_rst   = rstb;

    assign rsp_valid = (count != '0) & ~rstb;
    assign rsp_rdata = rstb ? '0 : fifo[rd_ptr];
    assign pop       = rsp_valid & rsp_ready;
    assign push      = push_tag & ~rstb;
    assign busy      = busy_q & ~rstb;

    // Credit update: one credit per tracked access, returned on each pop
    always_comb begin
        credits_next = credits;
        case ({tracked, pop})
            2'b10:   credits_next = credits - CW'(1);
            2'b01:   credits_next = credits + CW'(1);
            default: credits_next = credits;
        endcase
    end

    // Credit and busy registers
    always_ff @(posedge clka) begin
        if (rstb) begin
            credits <= CREDITS_FULL;
            busy_q  <= 1'b0;
        end else begin
            credits <= credits_next;
            busy_q  <= (credits_next != CREDITS_FULL);
        end
    end

    // First stage of the latency tag pipeline marks cycles whose RAM read is live
    always_ff @(posedge clka) begin
        if (rstb) begin
            tag0 <= 1'b0;
        end else begin
            tag0 <= tracked;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic tag1;

            // Second tag stage lines up with data leaving the RAM output register
            always_ff @(posedge clka) begin
                if (rstb) begin
                    tag1 <= 1'b0;
                end else begin
                    tag1 <= tag0;
                end
            end

            assign push_tag  = tag1;
            assign ram_regce = tag0 & ~rstb;
        end else begin : g_lat1
            assign push_tag  = tag0;
            assign ram_regce = 1'b0;
        end
    endgenerate

    // Response FIFO storage; content needs no reset since count gates visibility
    always_ff @(posedge clka) begin
        if (push) begin
            fifo[wr_ptr] <= ram_dout;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_xdpram_port_master.sv
// tb/tb_xdpram_port_master.sv - directed self-checking bench for xdpram_port_master
module tb_xdpram_port_master;

    localparam int W  = 16;
    localparam int AW = 6;

    logic           clka = 1'b0;
    logic           rstb;
    logic [2:0]     req_valid;
    logic [2:0]     req_ready;
    logic [2:0]     req_we;
    logic [2:0]     rsp_valid;
    logic [2:0]     rsp_ready;
    logic [2:0]     ram_en;
    logic [2:0]     ram_we;
    logic [2:0]     ram_regce;
    logic [2:0]     ram_rst;
    logic [2:0]     busy;
    logic [2:0]     ld_en;
    logic [AW-1:0]  ld_addr;
    logic [W-1:0]   ld_data;
    logic [AW-1:0]  req_addr  [3];
    logic [AW-1:0]  ram_addr  [3];
    logic [W-1:0]   req_wdata [3];
    logic [W-1:0]   rsp_rdata [3];
    logic [W-1:0]   ram_din   [3];

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    // Instance 0: RD_LATENCY=2, WR_RSP=0; instance 1: WR_RSP=1; instance 2: RD_LATENCY=1
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 2) ? 1 : 2;
        localparam int WRR = (g == 1) ? 1 : 0;

        logic [W-1:0] mem [64];
        logic [W-1:0] ram_q;
        logic [W-1:0] oreg;
        logic [W-1:0] dout;

        xdpram_port_master #(
            .RAM_WIDTH(W), .RAM_DEPTH(64), .RD_LATENCY(LAT), .RSP_DEPTH(4), .WR_RSP(WRR)
        ) u_dut (
            .clka(clka), .rstb(rstb),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
            .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_din(ram_din[g]),
            .ram_regce(ram_regce[g]), .ram_rst(ram_rst[g]), .ram_dout(dout), .busy(busy[g])
        );

        // Read-first BRAM port model with optional output register
        always @(posedge clka) begin
            if (ld_en[g]) begin
                mem[ld_addr] <= ld_data;
            end else if (ram_en[g]) begin
                ram_q <= mem[ram_addr[g]];
                if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
            end
            if (ram_rst[g]) oreg <= '0;
            else if (ram_regce[g]) oreg <= ram_q;
        end

        assign dout = (LAT == 2) ? oreg : ram_q;

        // Credits must make a push into a full FIFO impossible
        always @(negedge clka) begin
            if (!rstb) begin
                checks++;
                assert (!(u_dut.push && !u_dut.pop && u_dut.count == 4)) else begin
                    errors++;
                    $error("FAIL push_when_full inst=%0d observed=1 expected=0", g);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int g, input int a, input logic [W-1:0] d);
        @(negedge clka);
        ld_en    = '0;
        ld_en[g] = 1'b1;
        ld_addr  = AW'(a);
        ld_data  = d;
        @(negedge clka);
        ld_en    = '0;
    endtask

    initial begin
        int k;
        int acc;
        int fp;
        logic [W-1:0] exp4 [2];
        exp4[0] = 16'h1111;
        exp4[1] = 16'h2222;

        rstb      = 1'b1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        ld_en     = '0;
        ld_addr   = '0;
        ld_data   = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        // Reset: outputs forced even while a request is offered
        @(negedge clka);
        @(negedge clka);
        req_valid = 3'b111;
        req_we    = 3'b111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_ram_en",    32'(ram_en),    32'h0);
        chk("rst_ram_we",    32'(ram_we),    32'h0);
        chk("rst_ram_regce", 32'(ram_regce), 32'h0);
        chk("rst_ram_rst",   32'(ram_rst),   32'h7);
        chk("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'h0);

        @(negedge clka);
        rstb      = 1'b0;
        req_valid = '0;
        req_we    = '0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'h7);
        chk("ram_rst_low",     32'(ram_rst),   32'h0);

        preload(1, 3, 16'h1111);
        preload(2, 9, 16'hBEEF);

        // Test 1: write then read addr 5, response three cycles after read accept
        @(negedge clka);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 6'd5; req_wdata[0] = 16'hA5A5;
        #1;
        chk("t1_ram_en",   32'(ram_en[0]),   32'h1);
        chk("t1_ram_we",   32'(ram_we[0]),   32'h1);
        chk("t1_ram_addr", 32'(ram_addr[0]), 32'h5);
        chk("t1_ram_din",  32'(ram_din[0]),  32'hA5A5);
        @(negedge clka);
        req_we[0] = 1'b0;
        #1;
        chk("t1_rd_ram_we", 32'(ram_we[0]), 32'h0);
        chk("t1_wr_untracked_busy", 32'(busy[0]), 32'h0);
        @(negedge clka);
        req_valid[0] = 1'b0;
        #1;
        chk("t1_n1_ram_en", 32'(ram_en[0]),    32'h0);
        chk("t1_n1_valid",  32'(rsp_valid[0]), 32'h0);
        chk("t1_n1_busy",   32'(busy[0]),      32'h1);
        chk("t1_n1_regce",  32'(ram_regce[0]), 32'h1);
        @(negedge clka); #1;
        chk("t1_n2_valid", 32'(rsp_valid[0]), 32'h0);
        @(negedge clka); #1;
        chk("t1_n3_valid", 32'(rsp_valid[0]), 32'h1);
        chk("t1_n3_data",  32'(rsp_rdata[0]), 32'hA5A5);
        @(negedge clka); #1;
        chk("t1_n4_valid", 32'(rsp_valid[0]), 32'h0);
        chk("t1_n4_busy",  32'(busy[0]),      32'h0);

        for (int i = 0; i < 8; i++) preload(0, i, W'(16'h100 + i));

        // Test 2: back-to-back reads, ready never drops, data in order
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clka);
            req_valid[0] = (c < 8);
            req_we[0]    = 1'b0;
            req_addr[0]  = AW'(c);
            #1;
            if (c < 8) chk("t2_ready", 32'(req_ready[0]), 32'h1);
            if (rsp_valid[0]) begin
                chk("t2_data", 32'(rsp_rdata[0]), 32'(16'h100 + k));
                k++;
            end
        end
        chk("t2_count", 32'(k), 32'd8);

        // Test 3: backpressure stops acceptance at the credit limit
        rsp_ready[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            req_valid[0] = 1'b1;
            req_addr[0]  = AW'(acc);
            #1;
            if (req_ready[0]) acc++;
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_ready_low", 32'(req_ready[0]), 32'h0);
        k  = 0;
        fp = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clka);
            req_valid[0] = 1'b0;
            rsp_ready[0] = 1'b1;
            #1;
            if (fp >= 0 && c == fp + 1) chk("t3_ready_after_pop", 32'(req_ready[0]), 32'h1);
            if (rsp_valid[0]) begin
                if (fp < 0) begin
                    fp = c;
                    chk("t3_ready_before_pop", 32'(req_ready[0]), 32'h0);
                end
                chk("t3_data", 32'(rsp_rdata[0]), 32'(16'h100 + k));
                k++;
            end
        end
        chk("t3_count", 32'(k), 32'd4);
        chk("t3_busy_idle", 32'(busy[0]), 32'h0);

        // Test 4: WR_RSP=1 write returns old content, following read returns new
        @(negedge clka);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 6'd3; req_wdata[1] = 16'h2222;
        #1;
        chk("t4_ram_we", 32'(ram_we[1]), 32'h1);
        @(negedge clka);
        req_we[1] = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            req_valid[1] = 1'b0;
            #1;
            if (rsp_valid[1]) begin
                if (k < 2) chk("t4_data", 32'(rsp_rdata[1]), 32'(exp4[k]));
                k++;
            end
        end
        chk("t4_count", 32'(k), 32'd2);

        // Test 5: reset with reads in flight discards them
        rsp_ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clka);
            req_valid[0] = 1'b1;
            req_addr[0]  = AW'(c + 1);
        end
        @(negedge clka);
        req_valid[0] = 1'b0;
        rstb = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid[0]), 32'h0);
        chk("t5_rst_ready", 32'(req_ready[0]), 32'h0);
        chk("t5_rst_busy",  32'(busy[0]),      32'h0);
        @(negedge clka);
        rstb = 1'b0;
        rsp_ready[0] = 1'b1;
        #1;
        chk("t5_ready_after", 32'(req_ready[0]), 32'h1);
        chk("t5_busy_after",  32'(busy[0]),      32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clka); #1;
            chk("t5_quiet", 32'(rsp_valid[0]), 32'h0);
        end
        @(negedge clka);
        req_valid[0] = 1'b1;
        req_addr[0]  = 6'd6;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            req_valid[0] = 1'b0;
            #1;
            if (rsp_valid[0]) begin
                chk("t5_data", 32'(rsp_rdata[0]), 32'h106);
                k++;
            end
        end
        chk("t5_count", 32'(k), 32'd1);

        // Test 6: RD_LATENCY=1 response two cycles after accept, regce held low
        @(negedge clka);
        rsp_ready[2] = 1'b1;
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 6'd9;
        #1;
        chk("t6_ram_en", 32'(ram_en[2]), 32'h1);
        @(negedge clka);
        req_valid[2] = 1'b0;
        #1;
        chk("t6_n1_valid", 32'(rsp_valid[2]), 32'h0);
        chk("t6_n1_regce", 32'(ram_regce[2]), 32'h0);
        @(negedge clka); #1;
        chk("t6_n2_valid", 32'(rsp_valid[2]), 32'h1);
        chk("t6_n2_data",  32'(rsp_rdata[2]), 32'hBEEF);
        @(negedge clka); #1;
        chk("t6_n3_valid", 32'(rsp_valid[2]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
